// File: rtl/mux_rr_nto1.sv
// -----------------------------------------------------------------------------
// mux_rr_nto1
//
// Purpose
//   N:1 data multiplexer with internal round-robin arbitration. Each of the N
//   producer channels has its own valid/ready handshake. The selected word is
//   captured in an output register that has its own valid/ready handshake
//   towards a single shared consumer. The register may be reloaded in the same
//   cycle that it is drained, so sustained throughput is one word per clock.
//
// Optional feature
//   MUX_RR_LOCK_EN : when defined, a channel that is still valid and whose
//                    previous word is the one held in the output register is
//                    granted again, and the round-robin pointer is not moved.
//                    This keeps multi-beat bursts contiguous. When undefined,
//                    the pointer moves after every grant.
//
// Parameters
//   WIDTH : data width per channel (>= 1)
//   N     : number of input channels (>= 1, any value)
//   SELW  : width of sel_o, max(1, $clog2(N))
//
// Ports
//   clk      in   1        rising-edge clock
//   reset    in   1        synchronous, active-high reset
//   x_i      in   N*WIDTH  channel data, channel k = x_i[k*WIDTH +: WIDTH]
//   valid_i  in   N        channel k offers a word
//   ready_o  out  N        one-hot or zero; channel k word taken this cycle
//   y_o      out  WIDTH    registered selected data
//   valid_o  out  1        y_o holds a valid word
//   ready_i  in   1        consumer takes y_o this cycle
//   sel_o    out  SELW     channel index of the word held in y_o
// -----------------------------------------------------------------------------
module mux_rr_nto1 #(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   x_i,
    input  logic [N-1:0]         valid_i,
    output logic [N-1:0]         ready_o,
    output logic [WIDTH-1:0]     y_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [SELW-1:0]      sel_o
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic [SELW-1:0]  sel_q,   sel_d;
    logic [SELW-1:0]  ptr_q,   ptr_d;   // first channel to search next time

    // -------------------------------------------------------------------------
    // Arbitration signals
    // -------------------------------------------------------------------------
    logic             accept;           // output register may load this cycle
    logic             lock_hit;         // burst lock re-grants sel_q
    logic             grant_found;
    logic [SELW-1:0]  grant_idx;
    logic [N-1:0]     grant_onehot;

    // Channel index base+offset, wrapped modulo N. offset is always < N and
    // base is always < N, so a single subtraction is enough for any N.
    function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base,
                                                 input int              offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= N) begin
            sum = sum - N;
        end
        return SELW'(sum);
    endfunction

    // A drained or empty output register can take a new word.
    assign accept = !valid_q || ready_i;

`ifdef MUX_RR_LOCK_EN
    // The channel whose word is currently held is still offering data: keep
    // granting it until it drops valid_i.
    assign lock_hit = valid_q && valid_i[sel_q];
`else
    assign lock_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Grant search: ptr, ptr+1, ..., N-1, 0, ... ; first valid channel wins.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path can leave it unassigned and infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        if (lock_hit) begin
            grant_found = 1'b1;
            grant_idx   = sel_q;
        end else begin
            for (int off = 0; off < N; off++) begin
                if (!grant_found && valid_i[wrap_idx(ptr_q, off)]) begin
                    grant_found = 1'b1;
                    grant_idx   = wrap_idx(ptr_q, off);
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        if (grant_found) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

    // No channel is acknowledged while reset is asserted or while the output
    // register is stalled by the consumer.
    assign ready_o = (accept && !reset) ? grant_onehot : '0;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (grant_found) begin
                valid_d = 1'b1;
                y_d     = x_i[int'(grant_idx)*WIDTH +: WIDTH];
                sel_d   = grant_idx;
                // A locked re-grant leaves the pointer at sel_q+1, so the
                // search resumes there once the burst ends.
                if (!lock_hit) begin
                    if (int'(grant_idx) == N - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_idx + SELW'(1);
                    end
                end
            end else begin
                // Nothing to load: the held word (if any) was just consumed.
                valid_d = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its next value from the same pre-edge snapshot.
        if (reset) begin
            // NOTE: the data register is reset too, because y_o is a visible
            // output that must read zero after reset; it is a single word, not
            // a memory array, so the cost is one reset per bit.
            valid_q <= 1'b0;
            y_q     <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign valid_o = valid_q;
    assign y_o     = y_q;
    assign sel_o   = sel_q;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_nto1
//
// Self-checking bench for mux_rr_nto1 (WIDTH=8, N=4). A behavioural model
// predicts the grant and the output register; a queue of accepted words checks
// that every word reaches the consumer exactly once and in grant order.
// -----------------------------------------------------------------------------
module tb_mux_rr_nto1;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [N*WIDTH-1:0]  x_i;
    logic [N-1:0]        valid_i;
    logic [N-1:0]        ready_o;
    logic [WIDTH-1:0]    y_o;
    logic                valid_o;
    logic                ready_i;
    logic [SELW-1:0]     sel_o;

    mux_rr_nto1 #(.WIDTH(WIDTH), .N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_i     (x_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .y_o     (y_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sel_o   (sel_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit               m_valid;
    logic [WIDTH-1:0] m_y;
    int               m_sel;
    int               m_ptr;
    logic [WIDTH-1:0] sb[$];
    logic [N-1:0]     obs_ready;   // ready_o sampled in the last cycle

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [WIDTH-1:0] d);
        x_i[k*WIDTH +: WIDTH] = d;
    endtask

    // One clock. Inputs are already applied; checks the combinational grant
    // mid-cycle and the registered outputs 1 time unit after the edge.
    task automatic cycle(output int g);
        bit               acc;
        bit               lock;
        logic [N-1:0]     exp_ready;
        logic [WIDTH-1:0] xg;
        logic [WIDTH-1:0] front;
        #2;
        acc  = !m_valid || ready_i;
        g    = -1;
        lock = 1'b0;
        if (!reset && acc) begin
`ifdef MUX_RR_LOCK_EN
            if (m_valid && valid_i[m_sel]) begin
                g    = m_sel;
                lock = 1'b1;
            end
`endif
            if (g < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (valid_i[(m_ptr + k) % N]) begin
                        g = (m_ptr + k) % N;
                        break;
                    end
                end
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = ready_o;
        check("ready_o", 32'(ready_o), 32'(exp_ready));

        // Scoreboard: a consumed word must be the oldest accepted one.
        if (!reset && valid_o && ready_i) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                front = sb.pop_front();
                check("sb_word", 32'(y_o), 32'(front));
            end
        end
        xg = '0;
        if (g >= 0) begin
            xg = x_i[g*WIDTH +: WIDTH];
            sb.push_back(xg);
        end
        if (reset) sb.delete();

        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0;
            m_y     = '0;
            m_sel   = 0;
            m_ptr   = 0;
        end else if (acc) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_y     = xg;
                m_sel   = g;
                if (!lock) m_ptr = (g + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        check("valid_o", 32'(valid_o), 32'(m_valid));
        check("y_o",     32'(y_o),     32'(m_y));
        check("sel_o",   32'(sel_o),   32'(m_sel));
    endtask

    task automatic do_reset(input int cycles);
        int g;
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) cycle(g);
        reset = 1'b0;
    endtask

    initial begin
        int g;
        int exp_sel;
        m_valid = 1'b0;
        m_y     = '0;
        m_sel   = 0;
        m_ptr   = 0;
        ready_i = 1'b1;
        x_i     = '0;
        for (int k = 0; k < N; k++) set_ch(k, WIDTH'(8'h10 + k));

        // 1. Reset with all channels valid: nothing acked, outputs zero.
        valid_i = 4'hF;
        do_reset(2);
        check("t1_ready",  32'(obs_ready), 32'd0);
        check("t1_valid",  32'(valid_o),   32'd0);
        check("t1_y",      32'(y_o),       32'd0);
        check("t1_sel",    32'(sel_o),     32'd0);

        // 2. Single channel 2 with 0xA5.
        valid_i = 4'b0100;
        set_ch(2, 8'hA5);
        cycle(g);
        check("t2_ready", 32'(obs_ready), 32'b0100);
        check("t2_y",     32'(y_o),       32'hA5);
        check("t2_sel",   32'(sel_o),     32'd2);
        check("t2_valid", 32'(valid_o),   32'd1);
        valid_i = '0;

        // 3. All channels valid for 8 clocks from a fresh pointer.
        do_reset(1);
        for (int k = 0; k < N; k++) set_ch(k, WIDTH'(8'h30 + k));
        valid_i = 4'hF;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(g);
`ifdef MUX_RR_LOCK_EN
            exp_sel = 0;
`else
            exp_sel = i % N;
`endif
            check("t3_sel",   32'(sel_o),   32'(exp_sel));
            check("t3_valid", 32'(valid_o), 32'd1);
        end

        // 4. Backpressure for 3 clocks, then release.
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(g);
            check("t4_hold_ready", 32'(obs_ready), 32'd0);
            check("t4_hold_sel",   32'(sel_o),     32'(exp_sel));
        end
        ready_i = 1'b1;
        cycle(g);
        check("t4_release_ready", 32'(obs_ready), 32'b0001);

        // 5. Wrap: grant ch2 (ptr=3), then only ch0/ch1 valid.
        do_reset(1);
        valid_i = 4'b0100;
        cycle(g);
        check("t5_first", 32'(sel_o), 32'd2);
        valid_i = 4'b0011;
        cycle(g);
        check("t5_wrap0", 32'(sel_o), 32'd0);
        cycle(g);
`ifdef MUX_RR_LOCK_EN
        check("t5_next", 32'(sel_o), 32'd0);
`else
        check("t5_next", 32'(sel_o), 32'd1);
`endif

        // 6. Two channels held valid for 4 clocks.
        do_reset(1);
        valid_i = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            cycle(g);
`ifdef MUX_RR_LOCK_EN
            check("t6_sel", 32'(sel_o), 32'd0);
`else
            check("t6_sel", 32'(sel_o), 32'(i % 2));
`endif
        end

        // 7. Reset while a word is held: discarded, nothing acked.
        valid_i = 4'hF;
        ready_i = 1'b0;
        cycle(g);
        do_reset(1);
        check("t7_ready", 32'(obs_ready), 32'd0);
        check("t7_valid", 32'(valid_o),   32'd0);
        check("t7_y",     32'(y_o),       32'd0);

        // 8. Random traffic. Producers hold data stable until acked.
        valid_i = '0;
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!valid_i[k] && $urandom_range(0, 2) != 0) begin
                    valid_i[k] = 1'b1;
                    set_ch(k, WIDTH'($urandom));
                end
            end
            ready_i = ($urandom_range(0, 3) != 0);
            cycle(g);
            if (g >= 0) valid_i[g] = 1'b0;
        end

        // Drain: every accepted word must have left exactly once.
        valid_i = '0;
        ready_i = 1'b1;
        cycle(g);
        cycle(g);
        check("drain_valid", 32'(valid_o),   32'd0);
        check("drain_sb",    32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
